clken_gen_multi: RTL and testbench
==================================

Name: clken_gen_multi

Overview:
- Parametrised, runtime-reconfigurable multi-channel clock-enable generator with lock indication.
- Derives NUM_CH divided clock-enable strobes and 50%-duty square waves from one reference clock. Each channel has its own divisor and phase offset.
- A lock counter gates output activity after reset and after every reconfiguration.
- Sits beside the fabric PLL wrappers. It generates slow, phase-aligned rates (pixel/SPI/sample ticks) without spending another PLL.

Parameters:
- NUM_CH, 3, number of output channels (1..16).
- DIV_W, 16, width of divisor and phase fields.
- LOCK_CYCLES, 256, cycles spent in LOCKING before locked asserts (>=1).
- DEF_DIV, 2, reset divisor for every channel.
- CH_W, clog2(NUM_CH) min 1, derived width of cfg_ch.

Ports:
- refclk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  new divisor; 0 is treated as 1.
- cfg_phase  in  DIV_W  new phase offset, in refclk cycles.
- ch_enable  in  NUM_CH  per-channel run enable.
- clk_en  out  NUM_CH  one-cycle strobe per divided period.
- outclk  out  NUM_CH  registered square wave at refclk/div.
- locked  out  1  outputs valid and phase-aligned.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; div[i]=DEF_DIV; phase[i]=0; cnt[i]=0.
  - clk_en=0, outclk=0, locked=0, cfg_ready=0.
- States: IDLE, LOCKING, LOCKED, RECONF.
  - IDLE: goes to LOCKING on the first clock after reset release.
  - LOCKING: lock counter counts from 0. The transition to LOCKED happens so that locked=1 exactly LOCKING_entry_cycle + LOCK_CYCLES.
  - LOCKED: steady running state; locked=1 only here.
  - RECONF: lasts 1 cycle, then LOCKING with the lock counter cleared.
- cfg_ready=1 in LOCKING and LOCKED, 0 in IDLE and RECONF. A transfer happens when cfg_valid && cfg_ready on a rising edge.
- Accepted transfer with cfg_ch < NUM_CH:
  - div[cfg_ch] and phase[cfg_ch] load at that edge; next state is RECONF and locked drops the next cycle.
  - A transfer during LOCKING restarts the lock count.
  - Stored phase is min(cfg_phase, div_eff-1), where div_eff = max(cfg_div,1).
- Accepted transfer with cfg_ch >= NUM_CH: consumed, no register change, no state change.
- In IDLE, LOCKING and RECONF, for all channels:
  - cnt[i] is held at phase[i]; clk_en=0, outclk=0.
- In LOCKED with ch_enable[i]=1:
  - cnt[i] advances by 1 per cycle and wraps from div_eff-1 to 0.
  - clk_en[i]=1 in exactly the cycles where cnt[i]==div_eff-1.
  - outclk[i]=1 in exactly the cycles where cnt[i] < ceil(div_eff/2).
  - Both outputs must come directly from flops (no decode glitches).
- Latency: in the first LOCKED cycle cnt[i]=phase[i], so all channels with equal phase start coincident. div_eff=1 gives clk_en=1 and outclk=1 every cycle.
- ch_enable[i]=0: cnt[i] is held at phase[i] and clk_en[i]=outclk[i]=0. On re-enable the channel counts from phase[i] and is not realigned to the other channels.
- A change of ch_enable does not affect locked.
- rst asserted mid-operation: everything returns immediately to the reset values, including configured divisors, which revert to DEF_DIV.
- Counters are DIV_W bits wide; the maximum divisor is 2^DIV_W-1 with no overflow.

Test Plan:
- Reset release, defaults (LOCK_CYCLES=256, DEF_DIV=2):
  - locked rises 257 cycles after the release edge.
  - All clk_en pulse every 2nd cycle, outclk alternates 1/0, all channels in phase.
- Configure ch1 div=5 phase=0 while LOCKED:
  - cfg_ready=0 next cycle; locked=0 for 1+256 cycles.
  - Then clk_en[1] period is 5, outclk[1] high 3 / low 2, ch0/ch2 still period 2.
- Configure ch2 div=4 phase=2, ch0 div=4 phase=0:
  - After lock, clk_en[2] leads clk_en[0] by 2 cycles.
  - A phase=9 with div=4 is clamped to 3.
- cfg_div=0 on ch0: treated as 1; clk_en[0] and outclk[0] held at 1 while LOCKED.
- cfg_ch=3 with NUM_CH=3: accepted in a single cycle; locked stays 1; no output change.
- Mid-operation and mid-lock events:
  - Deassert ch_enable[1] mid-period: outputs go to 0 at once; re-enable restarts from phase.
  - rst pulse mid-lock: outputs go to 0 asynchronously and divisors revert to 2.
  - Second cfg accepted during LOCKING: the lock count restarts from that transfer.

Source files
------------

// File: rtl/clken_gen_multi.sv
// ---------------------------------------------------------------------------
// clken_gen_multi
//
// Multi-channel clock-enable generator with lock indication.
// It derives NUM_CH divided clock-enable strobes and 50%-duty square waves
// from refclk. Each channel has a runtime-programmable divisor and phase
// offset. After reset, and after every accepted reconfiguration, a lock
// counter keeps all outputs quiet for LOCK_CYCLES cycles. All channels then
// start together from their phase values.
//
// Ports
//   refclk     in   sole clock, rising edge
//   rst        in   asynchronous, active-low reset
//   cfg_valid  in   configuration request
//   cfg_ready  out  configuration can be accepted (LOCKING / LOCKED)
//   cfg_ch     in   target channel (values >= NUM_CH are consumed and ignored)
//   cfg_div    in   new divisor (0 is treated as 1)
//   cfg_phase  in   new phase offset in refclk cycles (clamped to div-1)
//   ch_enable  in   per-channel run enable
//   clk_en     out  one-cycle strobe per divided period (registered)
//   outclk     out  square wave at refclk/div (registered)
//   locked     out  outputs valid and phase-aligned
// ---------------------------------------------------------------------------
module clken_gen_multi #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 256,
    parameter int DEF_DIV     = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKING,
        ST_LOCKED,
        ST_RECONF
    } state_t;

    state_t state, state_next;

    logic [LK_W-1:0]   lock_cnt;
    logic              lock_done;
    logic              xfer_hit;

    logic [DIV_W-1:0]  div_q  [NUM_CH];
    logic [DIV_W-1:0]  ph_q   [NUM_CH];
    logic [DIV_W-1:0]  cnt_q  [NUM_CH];
    logic [DIV_W-1:0]  div_n  [NUM_CH];
    logic [DIV_W-1:0]  ph_n   [NUM_CH];
    logic [DIV_W-1:0]  cnt_n  [NUM_CH];
    logic [NUM_CH-1:0] run_q;
    logic [NUM_CH-1:0] run_n;
    logic [NUM_CH-1:0] en_n;
    logic [NUM_CH-1:0] oc_n;

    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] p,
                                                     input logic [DIV_W-1:0] de);
        return (p > de - DIV_W'(1)) ? de - DIV_W'(1) : p;
    endfunction

    // ceil(d/2), one bit wider so the maximum divisor does not overflow
    function automatic logic [DIV_W:0] half_div(input logic [DIV_W-1:0] d);
        return ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
    endfunction

    // State register
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-channel next values
    always_comb begin
        state_next = state;
        xfer_hit   = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);
        lock_done  = (lock_cnt == LK_W'(LOCK_CYCLES - 1));

        case (state)
            ST_IDLE:    state_next = ST_LOCKING;
            ST_LOCKING: begin
                if (xfer_hit)       state_next = ST_RECONF;
                else if (lock_done) state_next = ST_LOCKED;
            end
            ST_LOCKED:  if (xfer_hit) state_next = ST_RECONF;
            ST_RECONF:  state_next = ST_LOCKING;
            default:    state_next = ST_IDLE;
        endcase

        run_n = '0;
        en_n  = '0;
        oc_n  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_n[i] = div_q[i];
            ph_n[i]  = ph_q[i];
            if (xfer_hit && (32'(cfg_ch) == i)) begin
                div_n[i] = eff_div(cfg_div);
                ph_n[i]  = clamp_phase(cfg_phase, eff_div(cfg_div));
            end

            // Outputs are registered, so they are decoded from the counter
            // value that the channel will hold in the coming cycle. A channel
            // that was not running in this cycle restarts from its phase.
            run_n[i] = (state_next == ST_LOCKED) && ch_enable[i];
            if (run_n[i]) begin
                if (run_q[i]) begin
                    cnt_n[i] = (cnt_q[i] == div_q[i] - DIV_W'(1)) ? '0
                                                                  : cnt_q[i] + DIV_W'(1);
                end else begin
                    cnt_n[i] = ph_q[i];
                end
            end else begin
                cnt_n[i] = ph_n[i];
            end

            en_n[i] = run_n[i] && (cnt_n[i] == div_q[i] - DIV_W'(1));
            oc_n[i] = run_n[i] && ({1'b0, cnt_n[i]} < half_div(div_q[i]));
        end
    end

    // Lock counter and registered status outputs
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lock_cnt  <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            lock_cnt  <= (state == ST_LOCKING && state_next == ST_LOCKING)
                         ? lock_cnt + LK_W'(1) : '0;
            locked    <= (state_next == ST_LOCKED);
            cfg_ready <= (state_next == ST_LOCKING) || (state_next == ST_LOCKED);
        end
    end

    // Per-channel configuration, counters and output flops
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_W'(DEF_DIV);
                ph_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            run_q  <= '0;
            clk_en <= '0;
            outclk <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_n[i];
                ph_q[i]  <= ph_n[i];
                cnt_q[i] <= cnt_n[i];
            end
            run_q  <= run_n;
            clk_en <= en_n;
            outclk <= oc_n;
        end
    end

endmodule

// File: tb/tb_clken_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_clken_gen_multi
//
// Randomised bench for clken_gen_multi. The reference model tracks the cycle
// number, the cycle at which locked is due, and the cycle at which each
// channel started running. The expected counter value is then
// (phase + cycles_since_start) mod div.
// ---------------------------------------------------------------------------
module tb_clken_gen_multi;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 16;
    localparam int LOCK_CYCLES = 256;
    localparam int DEF_DIV     = 2;
    localparam int CH_W        = 2;
    localparam int N_ITER      = 14000;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] outclk;
    logic              locked;

    always #5 refclk = ~refclk;

    clken_gen_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEF_DIV     (DEF_DIV),
        .CH_W        (CH_W)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .ch_enable (ch_enable),
        .clk_en    (clk_en),
        .outclk    (outclk),
        .locked    (locked)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int cyc;
    int lock_at;
    int reconf_at;
    int mdiv      [NUM_CH];
    int mph       [NUM_CH];
    int run_since [NUM_CH];
    bit running   [NUM_CH];

    function automatic void model_reset();
        cyc       = 0;
        lock_at   = 1 + LOCK_CYCLES;
        reconf_at = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            mdiv[i]      = DEF_DIV;
            mph[i]       = 0;
            run_since[i] = 0;
            running[i]   = 1'b0;
        end
    endfunction

    function automatic bit m_ready(input int c);
        return (c >= 1) && (c != reconf_at);
    endfunction

    // Advance the model across one rising edge using the inputs seen there.
    function automatic void model_step();
        int n;
        int d;
        int ch;
        n  = cyc + 1;
        ch = int'(cfg_ch);
        if (cfg_valid && m_ready(cyc) && ch < NUM_CH) begin
            d         = (int'(cfg_div) == 0) ? 1 : int'(cfg_div);
            mdiv[ch]  = d;
            mph[ch]   = (int'(cfg_phase) > d - 1) ? d - 1 : int'(cfg_phase);
            reconf_at = n;
            lock_at   = n + 1 + LOCK_CYCLES;
        end
        cyc = n;
        for (int i = 0; i < NUM_CH; i++) begin
            bit r;
            r = (cyc >= lock_at) && ch_enable[i];
            if (r && !running[i]) run_since[i] = cyc;
            running[i] = r;
        end
    endfunction

    task automatic check_all();
        check("locked", 32'(locked), 32'(cyc >= lock_at));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready(cyc)));
        for (int i = 0; i < NUM_CH; i++) begin
            int c;
            bit e;
            bit o;
            e = 1'b0;
            o = 1'b0;
            if (running[i]) begin
                c = (mph[i] + (cyc - run_since[i])) % mdiv[i];
                e = (c == mdiv[i] - 1);
                o = (c < (mdiv[i] + 1) / 2);
            end
            check($sformatf("clk_en[%0d]", i), 32'(clk_en[i]), 32'(e));
            check($sformatf("outclk[%0d]", i), 32'(outclk[i]), 32'(o));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'(0));
        check({tag, "_ready"},  32'(cfg_ready), 32'(0));
        check({tag, "_clk_en"}, 32'(clk_en), 32'(0));
        check({tag, "_outclk"}, 32'(outclk), 32'(0));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(negedge refclk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b1;
        #1;
        check_all();
    endtask

    task automatic drive(input bit allow_cfg);
        int k;
        cfg_valid = allow_cfg && ($urandom_range(0, 399) == 0);
        cfg_ch    = CH_W'($urandom_range(0, 3));
        cfg_div   = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(900, 1100))
                                               : DIV_W'($urandom_range(0, 9));
        cfg_phase = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 1200))
                                               : DIV_W'($urandom_range(0, 12));
        if (allow_cfg && $urandom_range(0, 149) == 0) begin
            k = $urandom_range(0, NUM_CH - 1);
            ch_enable[k] = ~ch_enable[k];
        end
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        ch_enable = '1;

        #12;
        check_reset_outputs("por");

        @(negedge refclk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();

        for (int it = 0; it < N_ITER; it++) begin
            if (it == 5000 || it == 10000) do_reset();
            // Quiet start so the default lock time and defaults are observed.
            drive(it >= 400);
            @(posedge refclk);
            #1;
            model_step();
            check_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
